wave_analyzer: RTL and testbench

Measurement block at the receiving end of the waveform/modulation chain: it takes the 16-bit signed stream the generator path produces (raw, modulated or demodulated) and measures it. Once triggered, it detects rising zero crossings with programmable hysteresis and counts the clocks spanned by N full periods. Over the same window it tracks signed peak maximum and minimum. Software derives frequency and amplitude from the latched results, which closes the loop for self-test of the MAWG output.

---
 rtl/wave_analyzer_pkg.sv | 16 +
 rtl/wave_analyzer_if.sv | 28 ++
 rtl/wave_analyzer_zero_cross_detector.sv | 60 ++++++
 rtl/wave_analyzer.sv | 147 ++++++++++++++
 tb/tb_wave_analyzer.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/wave_analyzer_pkg.sv
// Shared widths and FSM encoding for the waveform measurement block.
package wave_analyzer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int CNT_W    = 32;
  localparam int NCYC_W   = 8;
  localparam int HYST_W   = 15;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

endpackage

// File: rtl/wave_analyzer_if.sv
// Control, sample and result bundle between software/stimulus and wave_analyzer.
interface wave_analyzer_if;
  import wave_analyzer_pkg::*;

  logic                       start;
  logic signed [SAMPLE_W-1:0] signal;
  logic [HYST_W-1:0]          hysteresis;
  logic [NCYC_W-1:0]          num_cycles;
  logic [CNT_W-1:0]           timeout;
  logic                       busy;
  logic                       done;
  logic                       valid;
  logic                       timed_out;
  logic [CNT_W-1:0]           period_sum;
  logic signed [SAMPLE_W-1:0] peak_max;
  logic signed [SAMPLE_W-1:0] peak_min;

  modport master (
    output start, signal, hysteresis, num_cycles, timeout,
    input  busy, done, valid, timed_out, period_sum, peak_max, peak_min
  );

  modport slave (
    input  start, signal, hysteresis, num_cycles, timeout,
    output busy, done, valid, timed_out, period_sum, peak_max, peak_min
  );

endinterface

// File: rtl/wave_analyzer_zero_cross_detector.sv
// Registers the sample stream and flags rising zero crossings through a
// hysteresis dead band; runs continuously regardless of the measurement FSM.
module zero_cross_detector
  import wave_analyzer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] signal,
  input  logic [HYST_W-1:0]          hysteresis,
  output logic signed [SAMPLE_W-1:0] s_q,
  output logic                       rise
);

  logic signed [SAMPLE_W:0] s_ext;
  logic signed [SAMPLE_W:0] hyst_pos;
  logic signed [SAMPLE_W:0] hyst_neg;
  logic                     above;
  logic                     below;
  logic                     pol;
  logic                     pol_d;
  logic                     known;
  logic                     known_d;

  // One extra bit so that -hysteresis never wraps against the sample range.
  always_comb begin
    s_ext    = {s_q[SAMPLE_W-1], s_q};
    hyst_pos = {2'b00, hysteresis};
    hyst_neg = -hyst_pos;
    above    = (s_ext > hyst_pos);
    below    = (s_ext < hyst_neg);
  end

  always_ff @(posedge clk) begin
    s_q <= signal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pol     <= 1'b0;
      pol_d   <= 1'b0;
      known   <= 1'b0;
      known_d <= 1'b0;
    end else begin
      if (above) begin
        pol <= 1'b1;
      end else if (below) begin
        pol <= 1'b0;
      end
      if (above || below) begin
        known <= 1'b1;
      end
      pol_d   <= pol;
      known_d <= known;
    end
  end

  // known_d gates out the very first polarity acquisition after reset.
  assign rise = pol & ~pol_d & known_d;

endmodule

// File: rtl/wave_analyzer.sv
// Measures N full periods of a signed stream (rising zero crossings) plus the
// signed peak range over the same window, with an optional busy timeout.
module wave_analyzer
  import wave_analyzer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wave_analyzer_if.slave bus
);

  state_t                     state;
  state_t                     state_nx;
  logic signed [SAMPLE_W-1:0] s_q;
  logic                       rise;
  logic [NCYC_W-1:0]          n_lat;
  logic [NCYC_W-1:0]          cyc_cnt;
  logic [CNT_W-1:0]           tmo_lat;
  logic [CNT_W-1:0]           tmo_cnt;
  logic [CNT_W-1:0]           period_cnt;
  logic [CNT_W-1:0]           res_period;
  logic signed [SAMPLE_W-1:0] res_max;
  logic signed [SAMPLE_W-1:0] res_min;
  logic                       res_valid;
  logic                       res_tmo;
  logic                       terminal;
  logic                       expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] smax(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] smin(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    return (a < b) ? a : b;
  endfunction

  zero_cross_detector u_zcd (
    .clk        (clk),
    .rst        (rst),
    .signal     (bus.signal),
    .hysteresis (bus.hysteresis),
    .s_q        (s_q),
    .rise       (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A terminal rise takes priority over a coincident timeout expiry.
  always_comb begin
    state_nx = state;
    terminal = (state == MEASURE) && rise &&
               (({1'b0, cyc_cnt} + 9'd1) == {1'b0, n_lat});
    expire   = ((state == ARM) || (state == MEASURE)) &&
               (tmo_lat != '0) && (sat_inc(tmo_cnt) == tmo_lat);
    case (state)
      IDLE:    if (bus.start) state_nx = ARM;
      ARM: begin
        if (expire)    state_nx = DONE;
        else if (rise) state_nx = MEASURE;
      end
      MEASURE: if (terminal || expire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat      <= '0;
      cyc_cnt    <= '0;
      tmo_lat    <= '0;
      tmo_cnt    <= '0;
      period_cnt <= '0;
      res_period <= '0;
      res_max    <= '0;
      res_min    <= '0;
      res_valid  <= 1'b0;
      res_tmo    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            n_lat     <= (bus.num_cycles == '0) ? NCYC_W'(1) : bus.num_cycles;
            tmo_lat   <= bus.timeout;
            tmo_cnt   <= '0;
            res_valid <= 1'b0;
            res_tmo   <= 1'b0;
          end
        end
        ARM: begin
          tmo_cnt <= sat_inc(tmo_cnt);
          if (expire) begin
            res_tmo    <= 1'b1;
            res_valid  <= 1'b0;
            res_period <= '0;
          end else if (rise) begin
            period_cnt <= '0;
            cyc_cnt    <= '0;
            res_max    <= s_q;
            res_min    <= s_q;
          end
        end
        MEASURE: begin
          tmo_cnt    <= sat_inc(tmo_cnt);
          period_cnt <= sat_inc(period_cnt);
          res_max    <= smax(res_max, s_q);
          res_min    <= smin(res_min, s_q);
          if (terminal) begin
            res_period <= sat_inc(period_cnt);
            res_valid  <= 1'b1;
          end else if (expire) begin
            res_tmo    <= 1'b1;
            res_valid  <= 1'b0;
            res_period <= '0;
          end else if (rise) begin
            cyc_cnt <= cyc_cnt + NCYC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state == ARM) || (state == MEASURE);
  assign bus.done       = (state == DONE);
  assign bus.valid      = res_valid;
  assign bus.timed_out  = res_tmo;
  assign bus.period_sum = res_period;
  assign bus.peak_max   = res_max;
  assign bus.peak_min   = res_min;

endmodule

// File: tb/tb_wave_analyzer.sv
// Directed bench for wave_analyzer: square waves with and without edge noise,
// timeout, N=0, ignored restart, timeout/terminal coincidence and mid-run reset.
module tb_wave_analyzer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  wave_analyzer_if bus ();

  wave_analyzer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Negative half first; noisy mode replaces 3 clocks either side of each edge
  // with +/-50 alternating samples.
  function automatic logic signed [15:0] wave(input int k, input int period,
                                              input int amp, input bit noisy);
    int ph;
    int half;
    ph   = k % period;
    half = period / 2;
    if (noisy && (ph < 3 || ph >= period - 3 || (ph >= half - 3 && ph < half + 3)))
      return (k % 2 != 0) ? 16'sd50 : -16'sd50;
    return (ph < half) ? 16'(-amp) : 16'(amp);
  endfunction

  // Iteration k drives inputs, waits one edge, then observes (obs index k).
  // start is pulsed on iteration 0 and optionally again on iteration extra.
  task automatic run_wave(input int period, input int amp, input int phase,
                          input bit noisy, input int max_clocks, input int extra,
                          output int done_cnt, output int done_at,
                          output int busy0, output int busy_done, output int last_busy);
    done_cnt  = 0;
    done_at   = -1;
    busy0     = -1;
    busy_done = -1;
    last_busy = -1;
    for (int k = 0; k < max_clocks; k++) begin
      bus.signal = wave(k + phase, period, amp, noisy);
      bus.start  = (k == 0) || (k == extra);
      @(posedge clk);
      #1;
      if (k == 0) busy0 = int'(bus.busy);
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at   = k;
          busy_done = int'(bus.busy);
        end
      end
      last_busy = int'(bus.busy);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int dc, da, b0, bd, lb;
    bus.start      = 1'b0;
    bus.signal     = '0;
    bus.hysteresis = 15'd100;
    bus.num_cycles = 8'd4;
    bus.timeout    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_tmo", bus.timed_out, 0);
    check("rst_sum", bus.period_sum, 0);
    check("rst_max", bus.peak_max, 0);
    check("rst_min", bus.peak_min, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Clean square, P=100, N=4: first rise consumed at edge 50+2, terminal 400 later.
    run_wave(100, 1000, 0, 1'b0, 470, -1, dc, da, b0, bd, lb);
    check("sq_busy0", b0, 1);
    check("sq_done_cnt", dc, 1);
    check("sq_done_at", da, 452);
    check("sq_busy_at_done", bd, 0);
    check("sq_sum", bus.period_sum, 400);
    check("sq_max", bus.peak_max, 1000);
    check("sq_min", bus.peak_min, -1000);
    check("sq_valid", bus.valid, 1);
    check("sq_tmo", bus.timed_out, 0);

    // Edge noise inside the dead band.
    run_wave(100, 1000, 0, 1'b1, 480, -1, dc, da, b0, bd, lb);
    check("noise_done_cnt", dc, 1);
    check("noise_sum", bus.period_sum, 400);
    check("noise_max", bus.peak_max, 1000);
    check("noise_min", bus.peak_min, -1000);
    check("noise_valid", bus.valid, 1);

    // Same noise with no dead band: spurious crossings end the run early.
    bus.hysteresis = 15'd0;
    run_wave(100, 1000, 0, 1'b1, 120, -1, dc, da, b0, bd, lb);
    check("nohyst_done_cnt", dc, 1);
    check("nohyst_short", (bus.period_sum < 400), 1);
    check("nohyst_valid", bus.valid, 1);
    bus.hysteresis = 15'd100;

    // Constant zero, timeout 50.
    bus.timeout = 32'd50;
    run_wave(100, 0, 0, 1'b0, 80, -1, dc, da, b0, bd, lb);
    check("tmo_done_cnt", dc, 1);
    check("tmo_done_at", da, 50);
    check("tmo_busy_at_done", bd, 0);
    check("tmo_flag", bus.timed_out, 1);
    check("tmo_valid", bus.valid, 0);
    check("tmo_sum", bus.period_sum, 0);
    bus.timeout = '0;

    // num_cycles 0 acts as 1; a restart mid-MEASURE must be ignored.
    bus.num_cycles = 8'd0;
    run_wave(64, 1000, 0, 1'b0, 120, 60, dc, da, b0, bd, lb);
    check("n0_done_cnt", dc, 1);
    check("n0_done_at", da, 98);
    check("n0_sum", bus.period_sum, 64);
    check("n0_valid", bus.valid, 1);

    // P=40, N=2: terminal rise at edge 102, timeout expires on the same edge.
    bus.num_cycles = 8'd2;
    bus.timeout    = 32'd102;
    run_wave(40, 1000, 0, 1'b0, 130, -1, dc, da, b0, bd, lb);
    check("tie_done_cnt", dc, 1);
    check("tie_done_at", da, 102);
    check("tie_valid", bus.valid, 1);
    check("tie_tmo", bus.timed_out, 0);
    check("tie_sum", bus.period_sum, 80);
    bus.timeout = '0;

    // Reset in the middle of a measurement.
    bus.num_cycles = 8'd4;
    run_wave(100, 1000, 0, 1'b0, 200, -1, dc, da, b0, bd, lb);
    check("pre_rst_busy", lb, 1);
    check("pre_rst_done_cnt", dc, 0);
    bus.signal = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_valid", bus.valid, 0);
    check("midrst_tmo", bus.timed_out, 0);
    check("midrst_sum", bus.period_sum, 0);
    check("midrst_max", bus.peak_max, 0);
    check("midrst_min", bus.peak_min, 0);
    rst = 1'b0;

    // Positive-first after reset: that acquisition must not arm the window,
    // so the first real rise is consumed at edge 100+2.
    run_wave(100, 1000, 50, 1'b0, 520, -1, dc, da, b0, bd, lb);
    check("post_done_cnt", dc, 1);
    check("post_done_at", da, 502);
    check("post_sum", bus.period_sum, 400);
    check("post_valid", bus.valid, 1);
    check("post_max", bus.peak_max, 1000);
    check("post_min", bus.peak_min, -1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
